// File: rtl/cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// cp0_irq_ctrl
//   Interrupt sequencer for the CP0 register file.
//
//   The block detects rising edges on the IRQ lines and latches them as pending
//   requests. It picks the lowest-index request that is unmasked. It then asks
//   the pipeline to drain to an instruction boundary. At that boundary it writes
//   EPC, CAUSE and STATUS and redirects the PC to the vectored handler. An ERET
//   restores the PC from EPC and clears STATUS.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   irq, irq_mask       request lines (rising edge = request) and enables
//   safe, pc_next       pipeline is at a boundary; return address at that point
//   eret                ERET committed (1-cycle pulse)
//   hold_req            stop issuing and drain to a boundary
//   pc_redirect(_addr)  1-cycle PC load and flush, with its target
//   data_r_status/ehb/epc  CP0 read values (STATUS bit0 = in service)
//   en_w_epc, data_w_epc   EPC/CAUSE write strobe and EPC data
//   interrupter_no         winning IRQ index (CAUSE = 1 << interrupter_no)
//   en_w_status_set/reset  STATUS <= 1 / STATUS <= 0
//   pending                latched request bits
// -----------------------------------------------------------------------------
module cp0_irq_ctrl #(
  parameter int NUM_IRQ   = 8,
  parameter int VEC_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               safe,
  input  logic [31:0]        pc_next,
  input  logic               eret,
  output logic               hold_req,
  output logic               pc_redirect,
  output logic [31:0]        pc_redirect_addr,
  input  logic [31:0]        data_r_status,
  input  logic [31:0]        data_r_ehb,
  input  logic [31:0]        data_r_epc,
  output logic               en_w_epc,
  output logic [31:0]        data_w_epc,
  output logic [2:0]         interrupter_no,
  output logic               en_w_status_set,
  output logic               en_w_status_reset,
  output logic [NUM_IRQ-1:0] pending
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SAFE,
    S_ENTER,
    S_SERVICE,
    S_RETURN
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] pending_clr;
  logic [NUM_IRQ-1:0] eligible;
  logic [2:0]         irq_no_q, irq_no_d;
  logic [2:0]         winner;
  logic [31:0]        epc_q, epc_d;

  // Only STATUS bit0 matters here.
  logic unused_status;
  assign unused_status = ^data_r_status[31:1];

  assign eligible = pending_q & irq_mask;

  // The request being entered is retired in its ENTER cycle. A new edge on the
  // same line in that cycle wins over the clear, so no request is lost.
  assign pending_clr = (state_q == S_ENTER) ? (NUM_IRQ'(1) << irq_no_q) : '0;
  assign pending_d   = (pending_q & ~pending_clr) | (irq & ~irq_prev_q);

  // Fixed priority: the scan runs from the top down, so the lowest set index wins.
  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // NOTE: every signal written here gets a default first. A path that leaves a
  // combinational output unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    irq_no_d = irq_no_q;
    epc_d    = epc_q;
    unique case (state_q)
      S_IDLE: begin
        if (eret) begin
          state_d = S_RETURN;
        end else if ((|eligible) && !data_r_status[0]) begin
          irq_no_d = winner;
          state_d  = S_WAIT_SAFE;
        end
      end
      S_WAIT_SAFE: begin
        // An ERET abandons the entry. The request stays pending and is retried.
        if (eret) begin
          state_d = S_RETURN;
        end else if (safe) begin
          epc_d   = pc_next;
          state_d = S_ENTER;
        end
      end
      S_ENTER:   state_d = S_SERVICE;
      S_SERVICE: if (eret) state_d = S_RETURN;
      S_RETURN:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the state alone. The data outputs come from registers.
  always_comb begin
    hold_req          = 1'b0;
    pc_redirect       = 1'b0;
    pc_redirect_addr  = '0;
    en_w_epc          = 1'b0;
    en_w_status_set   = 1'b0;
    en_w_status_reset = 1'b0;
    unique case (state_q)
      S_WAIT_SAFE: hold_req = 1'b1;
      S_ENTER: begin
        en_w_epc         = 1'b1;
        en_w_status_set  = 1'b1;
        pc_redirect      = 1'b1;
        pc_redirect_addr = data_r_ehb + (32'(irq_no_q) << VEC_SHIFT);
      end
      S_RETURN: begin
        en_w_status_reset = 1'b1;
        pc_redirect       = 1'b1;
        pc_redirect_addr  = data_r_epc;
      end
      default: ;
    endcase
  end

  assign data_w_epc     = epc_q;
  assign interrupter_no = irq_no_q;
  assign pending        = pending_q;

  // NOTE: reset is synchronous. It is sampled only at the clock edge, so it sits
  // inside the edge-triggered block and is kept out of the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      irq_no_q   <= '0;
      epc_q      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments. That way every
      // register samples pre-edge values, whatever order the statements are in.
      state_q    <= state_d;
      irq_prev_q <= irq;
      pending_q  <= pending_d;
      irq_no_q   <= irq_no_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp0_irq_ctrl
//   Self-checking bench for cp0_irq_ctrl. It has three parts: a table of
//   per-cycle vectors, hand-written multi-cycle sequences, and a randomized run
//   checked every cycle against a behavioural model of the sequencer.
// -----------------------------------------------------------------------------
module tb_cp0_irq_ctrl;

  localparam int NUM_IRQ   = 8;
  localparam int VEC_SHIFT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq = '0;
  logic [7:0]  irq_mask = 8'hFF;
  logic        safe = 1'b0;
  logic [31:0] pc_next = '0;
  logic        eret = 1'b0;
  logic [31:0] ehb = 32'h100;
  logic        sw_status = 1'b0;
  logic [31:0] sw_epc = '0;
  logic        cp0_auto = 1'b0;
  logic        cp0_stat = 1'b0;
  logic [31:0] cp0_epc = '0;

  logic        hold_req, pc_redirect, en_w_epc, en_w_status_set, en_w_status_reset;
  logic [31:0] pc_redirect_addr, data_w_epc, data_r_status, data_r_epc;
  logic [2:0]  interrupter_no;
  logic [7:0]  pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // STATUS and EPC come either from the vector table (cp0_auto=0) or from a
  // small CP0 register model that follows the DUT write strobes on negedge.
  assign data_r_status = {31'b0, cp0_auto ? (cp0_stat | sw_status) : sw_status};
  assign data_r_epc    = cp0_auto ? cp0_epc : sw_epc;

  always @(negedge clk) begin
    if (cp0_auto) begin
      if (!rst_n) cp0_stat <= 1'b0;
      else if (en_w_status_set) cp0_stat <= 1'b1;
      else if (en_w_status_reset) cp0_stat <= 1'b0;
      if (en_w_epc) cp0_epc <= data_w_epc;
    end
  end

  cp0_irq_ctrl #(.NUM_IRQ(NUM_IRQ), .VEC_SHIFT(VEC_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .irq_mask(irq_mask), .safe(safe),
    .pc_next(pc_next), .eret(eret), .hold_req(hold_req), .pc_redirect(pc_redirect),
    .pc_redirect_addr(pc_redirect_addr), .data_r_status(data_r_status),
    .data_r_ehb(ehb), .data_r_epc(data_r_epc), .en_w_epc(en_w_epc),
    .data_w_epc(data_w_epc), .interrupter_no(interrupter_no),
    .en_w_status_set(en_w_status_set), .en_w_status_reset(en_w_status_reset),
    .pending(pending)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model. It is written from the sequencer's rules: a phase
  // number, a set of pending lines, and the latched winner and return address.
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_WAIT = 1, M_ENTER = 2, M_SERV = 3, M_RET = 4;
  int          m_mode = M_IDLE;
  logic [7:0]  m_pend = '0;
  logic [7:0]  m_prev = '0;
  int          m_no = 0;
  logic [31:0] m_epc = '0;

  always @(posedge clk) begin : model_blk
    automatic logic [7:0] nxt = m_pend;
    automatic int lowest = -1;
    if (!rst_n) begin
      m_mode <= M_IDLE; m_pend <= '0; m_prev <= '0; m_no <= 0; m_epc <= '0;
    end else begin
      if (m_mode == M_ENTER) nxt[m_no] = 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) if (irq[i] && !m_prev[i]) nxt[i] = 1'b1;
      for (int i = 0; i < NUM_IRQ; i++) if (lowest < 0 && m_pend[i] && irq_mask[i]) lowest = i;
      m_pend <= nxt;
      m_prev <= irq;
      case (m_mode)
        M_IDLE:
          if (eret) m_mode <= M_RET;
          else if (lowest >= 0 && !data_r_status[0]) begin m_no <= lowest; m_mode <= M_WAIT; end
        M_WAIT:
          if (eret) m_mode <= M_RET;
          else if (safe) begin m_epc <= pc_next; m_mode <= M_ENTER; end
        M_ENTER: m_mode <= M_SERV;
        M_SERV:  if (eret) m_mode <= M_RET;
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_check(input int cyc);
    logic [31:0] exp_addr;
    exp_addr = (m_mode == M_ENTER) ? ehb + 32'(m_no * (2 ** VEC_SHIFT)) :
               (m_mode == M_RET)   ? data_r_epc : 32'h0;
    check($sformatf("r%0d_hold", cyc), hold_req, m_mode == M_WAIT);
    check($sformatf("r%0d_redir", cyc), pc_redirect, m_mode == M_ENTER || m_mode == M_RET);
    check($sformatf("r%0d_addr", cyc), pc_redirect_addr, exp_addr);
    check($sformatf("r%0d_enepc", cyc), en_w_epc, m_mode == M_ENTER);
    check($sformatf("r%0d_set", cyc), en_w_status_set, m_mode == M_ENTER);
    check($sformatf("r%0d_reset", cyc), en_w_status_reset, m_mode == M_RET);
    check($sformatf("r%0d_wepc", cyc), data_w_epc, m_epc);
    check($sformatf("r%0d_no", cyc), interrupter_no, 32'(m_no));
    check($sformatf("r%0d_pend", cyc), pending, m_pend);
  endtask

  // Waits up to max negedges for a strobe: 0 en_w_epc, 1 hold_req, 2 status reset.
  task automatic wait_sig(input int which, input int max, output bit hit);
    hit = 1'b0;
    for (int c = 0; c < max && !hit; c++) begin
      @(negedge clk);
      case (which)
        0:       hit = en_w_epc;
        1:       hit = hold_req;
        default: hit = en_w_status_reset;
      endcase
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq = '0; eret = 1'b0; safe = 1'b0; sw_status = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Fields: rst irq mask safe pc eret status epc | hold redir addr en_epc wepc no set reset pend
  typedef struct {
    logic rst; logic [7:0] irq; logic [7:0] mask; logic safe; logic [31:0] pc;
    logic eret; logic st; logic [31:0] epc;
    logic hold; logic redir; logic [31:0] addr; logic en_epc; logic [31:0] wepc;
    logic [2:0] no; logic set; logic clr; logic [7:0] pend;
  } vec_t;

  vec_t tbl[14];

  initial begin : wdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit hit;
    // irq[3] entry with ehb=0x100, ERET to 0x40, masked irq[1], reset in WAIT_SAFE,
    // then a line that is already high when reset releases.
    tbl[0]  = '{0, 8'h00, 8'hFF, 1, 32'h1000, 0, 0, 32'h00, 0, 0, 32'h000, 0, 32'h0000, 0, 0, 0, 8'h00};
    tbl[1]  = '{1, 8'h08, 8'hFF, 1, 32'h1000, 0, 0, 32'h00, 0, 0, 32'h000, 0, 32'h0000, 0, 0, 0, 8'h08};
    tbl[2]  = '{1, 8'h08, 8'hFF, 1, 32'h1004, 0, 0, 32'h00, 1, 0, 32'h000, 0, 32'h0000, 3, 0, 0, 8'h08};
    tbl[3]  = '{1, 8'h08, 8'hFF, 1, 32'h1008, 0, 0, 32'h00, 0, 1, 32'h10C, 1, 32'h1008, 3, 1, 0, 8'h08};
    tbl[4]  = '{1, 8'h08, 8'hFF, 1, 32'h100C, 0, 1, 32'h00, 0, 0, 32'h000, 0, 32'h1008, 3, 0, 0, 8'h00};
    tbl[5]  = '{1, 8'h00, 8'hFF, 0, 32'h1010, 0, 1, 32'h00, 0, 0, 32'h000, 0, 32'h1008, 3, 0, 0, 8'h00};
    tbl[6]  = '{1, 8'h00, 8'hFF, 0, 32'h1014, 1, 1, 32'h40, 0, 1, 32'h040, 0, 32'h1008, 3, 0, 1, 8'h00};
    tbl[7]  = '{1, 8'h00, 8'hFF, 0, 32'h1018, 0, 0, 32'h40, 0, 0, 32'h000, 0, 32'h1008, 3, 0, 0, 8'h00};
    tbl[8]  = '{1, 8'h02, 8'hFD, 0, 32'h0000, 0, 0, 32'h40, 0, 0, 32'h000, 0, 32'h1008, 3, 0, 0, 8'h02};
    tbl[9]  = '{1, 8'h02, 8'hFD, 0, 32'h0000, 0, 0, 32'h40, 0, 0, 32'h000, 0, 32'h1008, 3, 0, 0, 8'h02};
    tbl[10] = '{1, 8'h02, 8'hFF, 0, 32'h0000, 0, 0, 32'h40, 1, 0, 32'h000, 0, 32'h1008, 1, 0, 0, 8'h02};
    tbl[11] = '{1, 8'h02, 8'hFF, 0, 32'h0000, 0, 0, 32'h40, 1, 0, 32'h000, 0, 32'h1008, 1, 0, 0, 8'h02};
    tbl[12] = '{0, 8'h02, 8'hFF, 0, 32'h0000, 0, 0, 32'h40, 0, 0, 32'h000, 0, 32'h0000, 0, 0, 0, 8'h00};
    tbl[13] = '{1, 8'h02, 8'hFF, 0, 32'h0000, 0, 0, 32'h40, 0, 0, 32'h000, 0, 32'h0000, 0, 0, 0, 8'h02};

    cp0_auto = 1'b0;
    ehb = 32'h100;
    for (int k = 0; k < 14; k++) begin
      rst_n = tbl[k].rst; irq = tbl[k].irq; irq_mask = tbl[k].mask; safe = tbl[k].safe;
      pc_next = tbl[k].pc; eret = tbl[k].eret; sw_status = tbl[k].st; sw_epc = tbl[k].epc;
      @(negedge clk);
      check($sformatf("v%0d_hold", k), hold_req, tbl[k].hold);
      check($sformatf("v%0d_redir", k), pc_redirect, tbl[k].redir);
      check($sformatf("v%0d_addr", k), pc_redirect_addr, tbl[k].addr);
      check($sformatf("v%0d_enepc", k), en_w_epc, tbl[k].en_epc);
      check($sformatf("v%0d_wepc", k), data_w_epc, tbl[k].wepc);
      check($sformatf("v%0d_no", k), interrupter_no, 32'(tbl[k].no));
      check($sformatf("v%0d_set", k), en_w_status_set, tbl[k].set);
      check($sformatf("v%0d_reset", k), en_w_status_reset, tbl[k].clr);
      check($sformatf("v%0d_pend", k), pending, tbl[k].pend);
    end

    // ---- Hand-written sequences, with the CP0 register model in the loop ----
    cp0_auto = 1'b1;
    irq_mask = 8'hFF;
    ehb = 32'h200;
    do_reset();

    // Simultaneous edges on irq 5 and 2: 2 goes first, then 5 without a new edge.
    irq = 8'h24; safe = 1'b1; pc_next = 32'h2000;
    wait_sig(0, 10, hit);
    check("pri_enter", hit, 1);
    check("pri_no2", interrupter_no, 2);
    check("pri_addr2", pc_redirect_addr, 32'h208);
    @(negedge clk);
    check("pri_pend", pending, 8'h20);
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    check("pri_ret_reset", en_w_status_reset, 1);
    check("pri_ret_addr", pc_redirect_addr, 32'h2000);
    wait_sig(0, 10, hit);
    check("pri_enter5", hit, 1);
    check("pri_no5", interrupter_no, 5);
    check("pri_addr5", pc_redirect_addr, 32'h214);
    @(negedge clk); eret = 1'b1; @(negedge clk); eret = 1'b0; @(negedge clk);

    // safe held low for 6 cycles in WAIT_SAFE.
    safe = 1'b0; irq = 8'h25;
    wait_sig(1, 10, hit);
    check("stall_hold", hit, 1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_hold", c), hold_req, 1);
      check($sformatf("stall%0d_noentry", c), en_w_epc, 0);
    end
    safe = 1'b1; pc_next = 32'h3456_7890;
    @(negedge clk);
    check("stall_enter", en_w_epc, 1);
    check("stall_epc", data_w_epc, 32'h3456_7890);
    check("stall_no", interrupter_no, 0);
    @(negedge clk); eret = 1'b1; @(negedge clk); eret = 1'b0; @(negedge clk);

    // STATUS set by software blocks entry; an ERET in IDLE still returns.
    sw_status = 1'b1; irq = 8'h35;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("blk%0d_hold", c), hold_req, 0);
    end
    check("blk_pend", pending, 8'h10);
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0; sw_status = 1'b0;
    check("idle_eret_reset", en_w_status_reset, 1);
    check("idle_eret_addr", pc_redirect_addr, 32'h3456_7890);
    wait_sig(0, 10, hit);
    check("unblk_enter", hit, 1);
    check("unblk_no", interrupter_no, 4);
    @(negedge clk); eret = 1'b1; @(negedge clk); eret = 1'b0; @(negedge clk);

    // Reset asserted during ENTER.
    irq = 8'hB5;
    wait_sig(0, 10, hit);
    check("rst_enter", hit, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_enepc", en_w_epc, 0);
    check("rst_redir", pc_redirect, 0);
    check("rst_set", en_w_status_set, 0);
    check("rst_pend", pending, 0);
    check("rst_no", interrupter_no, 0);
    check("rst_wepc", data_w_epc, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_high_edges", pending, 8'hB5);

    // ---- Randomized run against the model ----
    do_reset();
    ehb = $urandom;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      model_check(cyc);
      for (int i = 0; i < NUM_IRQ; i++) if ($urandom_range(7) == 0) irq[i] = ~irq[i];
      irq_mask = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
      safe = 1'($urandom_range(1));
      pc_next = $urandom;
      eret = ($urandom_range(9) == 0);
      rst_n = ($urandom_range(299) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
